// File: rtl/rvc_asap_pkg.sv
// Shared types and constants for the rvc core peripherals.
// Holds the UART TX state encoding, register offsets and divisor helper.
package rvc_asap_pkg;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } tx_state_t;

    localparam logic [1:0] UART_DATA_OFF = 2'd0;
    localparam logic [1:0] UART_STAT_OFF = 2'd1;
    localparam logic [1:0] UART_DIV_OFF  = 2'd2;
    localparam int         UART_CNT_W    = 5;

    // A zero divisor would stall the baud counter, so it is stored as 1.
    function automatic logic [15:0] div_merge(
        input logic [15:0] cur,
        input logic [15:0] wdata,
        input logic [1:0]  be
    );
        logic [15:0] v;
        v = cur;
        if (be[0]) v[7:0]  = wdata[7:0];
        if (be[1]) v[15:8] = wdata[15:8];
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/rvc_fifo.sv
// Synchronous FIFO with wrap-bit pointers and occupancy count.
// A pop frees a slot for a push in the same cycle when full.
module rvc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/rvc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data-memory bus.
// Stores to DATA queue bytes; the TX FSM drains them back-to-back.
module rvc_uart_tx
    import rvc_asap_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd434
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [31:0] AluOut,
    input  logic [31:0] RegRdData2,
    input  logic [3:0]  CtrlDMemByteEn,
    input  logic        CtrlDMemWrEn,
    input  logic        SelDMemWb,
    output logic        UartHit,
    output logic [31:0] UartRdData,
    output logic        UartTx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] divlat_q, divlat_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;

    logic [1:0]            off;
    logic                  wr_hit, push, pop;
    logic                  full, empty, busy, baud_end;
    logic [7:0]            head;
    logic [CW-1:0]         cnt;
    logic [UART_CNT_W-1:0] cnt5;
    logic                  unused_bits;

    assign UartHit  = AluOut[31:4] == BASE_ADDR[31:4];
    assign off      = AluOut[3:2];
    assign wr_hit   = CtrlDMemWrEn && UartHit;
    assign push     = wr_hit && off == UART_DATA_OFF &&
                      CtrlDMemByteEn[0];
    assign busy     = state_q != UTX_IDLE;
    assign baud_end = baud_q == 16'd0;
    assign cnt5     = UART_CNT_W'(cnt);

    assign unused_bits = ^{RegRdData2[31:16], AluOut[1:0],
                           CtrlDMemByteEn[3:2]};

    rvc_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_i   (Rst),
        .push_i  (push),
        .data_i  (RegRdData2[7:0]),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (cnt)
    );

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_hit && off == UART_DIV_OFF)
            div_d = div_merge(div_q, RegRdData2[15:0],
                              CtrlDMemByteEn[1:0]);
        if (wr_hit && off == UART_STAT_OFF &&
            CtrlDMemByteEn[0] && RegRdData2[3])
            ovf_d = 1'b0;
        if (push && full && !pop)
            ovf_d = 1'b1;
    end

    always_comb begin
        UartRdData = '0;
        if (UartHit && SelDMemWb) begin
            unique case (1'b1)
                off == UART_STAT_OFF:
                    UartRdData = {23'b0, cnt5, ovf_q,
                                  empty, full, busy};
                off == UART_DIV_OFF:
                    UartRdData = {16'b0, div_q};
                default: UartRdData = '0;
            endcase
        end
    end

    // Purely a decode of registered state so an async reset
    // returns the line to idle without waiting for a clock.
    always_comb begin
        unique case (state_q)
            UTX_START: UartTx = 1'b0;
            UTX_DATA:  UartTx = shift_q[0];
            default:   UartTx = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        divlat_d = divlat_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        pop      = 1'b0;
        unique case (state_q)
            UTX_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    divlat_d = div_q;
                    baud_d   = div_q - 16'd1;
                    state_d  = UTX_START;
                end
            end
            UTX_START: begin
                if (baud_end) begin
                    baud_d  = divlat_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = UTX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            UTX_DATA: begin
                if (baud_end) begin
                    baud_d = divlat_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = UTX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            UTX_STOP: begin
                if (baud_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_d  = head;
                        divlat_d = div_q;
                        baud_d   = div_q - 16'd1;
                        state_d  = UTX_START;
                    end else begin
                        state_d = UTX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q  <= UTX_IDLE;
            shift_q  <= '0;
            divlat_q <= DIV_RST;
            baud_q   <= '0;
            bit_q    <= '0;
            div_q    <= DIV_RST;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            divlat_q <= divlat_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rvc_uart_tx.sv
// Directed bench for rvc_uart_tx: register table plus serial-line
// scenarios decoded by an independent line monitor.
module tb_rvc_uart_tx;

    localparam logic [31:0] A_DATA = 32'h0000_3000;
    localparam logic [31:0] A_STAT = 32'h0000_3004;
    localparam logic [31:0] A_DIV  = 32'h0000_3008;
    localparam logic [31:0] A_RSV  = 32'h0000_300C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        we, sel;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;

    always #5 clk = ~clk;

    rvc_uart_tx dut (
        .Clock          (clk),
        .Rst            (rst),
        .AluOut         (addr),
        .RegRdData2     (wdata),
        .CtrlDMemByteEn (be),
        .CtrlDMemWrEn   (we),
        .SelDMemWb      (sel),
        .UartHit        (hit),
        .UartRdData     (rdata),
        .UartTx         (tx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Line monitor: samples mid-bit using the divisor the bench
    // expects for the frame that is starting.
    logic [7:0] rx_q[$];
    int         st_q[$];
    int         mon_div  = 4;
    bit         mon_busy = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                int         d;
                int         st;
                int         idx;
                logic [7:0] b;
                bit         ab;
                d = mon_div;
                st = cyc;
                ab = 0;
                b = '0;
                mon_busy = 1;
                for (int c = 1; c < 10 * d && !ab; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1;
                    end else if (c % d == d / 2) begin
                        idx = c / d;
                        if (idx == 0)
                            chk("start_bit", 32'(tx), 32'd0);
                        else if (idx < 9)
                            b[idx-1] = tx;
                        else
                            chk("stop_bit", 32'(tx), 32'd1);
                    end
                end
                if (!ab) begin
                    rx_q.push_back(b);
                    st_q.push_back(st);
                end
                mon_busy = 0;
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; we = 1'b1; sel = 1'b0;
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        we = 1'b0; be = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; we = 1'b0; sel = 1'b1;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget,
                               input string nm);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_busy(input int budget, input string nm);
        int c = 0;
        while (!mon_busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(mon_busy), 32'd1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        bit          s;
        logic [31:0] exp;
        logic        exp_hit;
        string       nm;
    } vec_t;

    function automatic vec_t v(input bit w, input logic [31:0] a,
                               input logic [31:0] d,
                               input logic [3:0] b, input bit s,
                               input logic [31:0] e,
                               input logic h, input string n);
        vec_t r;
        r.is_wr = w; r.a = a; r.d = d; r.b = b; r.s = s;
        r.exp = e; r.exp_hit = h; r.nm = n;
        return r;
    endfunction

    localparam int NV = 23;
    vec_t vt[NV];

    logic [31:0] r;
    logic [7:0]  t3[9];
    int          busy_n;
    int          last;
    int          cseq[$];

    initial begin
        vt[0]  = v(0, A_STAT, 0, 4'h0, 1, 32'h4, 1, "rst_status");
        vt[1]  = v(0, A_DIV, 0, 4'h0, 1, 32'd434, 1, "rst_div");
        vt[2]  = v(0, A_DATA, 0, 4'h0, 1, 32'h0, 1, "rd_data");
        vt[3]  = v(0, A_RSV, 0, 4'h0, 1, 32'h0, 1, "rd_rsv");
        vt[4]  = v(0, A_DIV, 0, 4'h0, 0, 32'h0, 1, "rd_nosel");
        vt[5]  = v(0, 32'h3010, 0, 4'h0, 1, 32'h0, 0, "rd_miss");
        vt[6]  = v(1, A_DIV, 0, 4'h3, 0, 32'h0, 1, "wr_div0");
        vt[7]  = v(0, A_DIV, 0, 4'h0, 1, 32'h1, 1, "div0_is1");
        vt[8]  = v(1, A_DIV, 32'h1234, 4'h1, 0, 32'h0, 1, "wr_lo");
        vt[9]  = v(0, A_DIV, 0, 4'h0, 1, 32'h34, 1, "div_lo");
        vt[10] = v(1, A_DIV, 32'hAB00, 4'h2, 0, 32'h0, 1, "wr_hi");
        vt[11] = v(0, A_DIV, 0, 4'h0, 1, 32'hAB34, 1, "div_hi");
        vt[12] = v(1, A_RSV, 32'hFFFF, 4'hF, 0, 32'h0, 1, "wr_rsv");
        vt[13] = v(1, A_DIV, 32'h0, 4'h4, 0, 32'h0, 1, "wr_div_be");
        vt[14] = v(0, A_DIV, 0, 4'h0, 1, 32'hAB34, 1, "div_keep");
        vt[15] = v(1, A_STAT, 32'h0, 4'h1, 0, 32'h0, 1, "wr_stat");
        vt[16] = v(0, A_STAT, 0, 4'h0, 1, 32'h4, 1, "stat_keep");
        vt[17] = v(1, 32'h2008, 32'h5, 4'hF, 0, 32'h0, 0, "wr_miss");
        vt[18] = v(0, A_DIV, 0, 4'h0, 1, 32'hAB34, 1, "div_miss");
        vt[19] = v(1, A_DATA, 32'h55, 4'h0, 0, 32'h0, 1, "wr_nobe");
        vt[20] = v(0, A_STAT, 0, 4'h0, 1, 32'h4, 1, "stat_nobe");
        vt[21] = v(1, A_DIV, 32'h4, 4'h3, 0, 32'h0, 1, "wr_div4");
        vt[22] = v(0, A_DIV, 0, 4'h0, 1, 32'h4, 1, "div4");

        rst = 1'b1;
        addr = '0; wdata = '0; be = '0; we = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            addr = vt[i].a; wdata = vt[i].d; be = vt[i].b;
            we = vt[i].is_wr; sel = vt[i].s;
            #1;
            chk({vt[i].nm, "_hit"}, 32'(hit), 32'(vt[i].exp_hit));
            chk(vt[i].nm, rdata, vt[i].exp);
            @(posedge clk);
            #1;
            we = 1'b0; sel = 1'b0; be = 4'h0;
        end
        repeat (5) @(negedge clk);
        chk("tbl_no_frame", 32'(rx_q.size()), 32'd0);

        // Single 0xA5 frame at DIV=4
        mon_div = 4;
        wr(A_DATA, 32'hA5, 4'h1);
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            rd(A_STAT, r);
            if (r[0]) busy_n++;
        end
        chk("t2_busy_cycles", 32'(busy_n), 32'd40);
        wait_frames(1, 100, "t2_frames");
        if (rx_q.size() == 1) begin
            chk("t2_byte", 32'(rx_q[0]), 32'hA5);
            chk("t2_latency", 32'(st_q[0] - wr_cyc), 32'd1);
        end

        // Nine back-to-back stores at DIV=2
        wr(A_DIV, 32'd2, 4'h3);
        mon_div = 2;
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 9; i++) t3[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'(t3[i]), 4'h1);
        last = -1;
        cseq.delete();
        for (int c = 0; c < 400 && rx_q.size() < 9; c++) begin
            rd(A_STAT, r);
            if (c == 0) chk("t3_status", r, 32'h83);
            if (int'(r[8:4]) != last) begin
                last = int'(r[8:4]);
                cseq.push_back(last);
            end
        end
        chk("t3_frames", 32'(rx_q.size()), 32'd9);
        chk("t3_cnt_seq_len", 32'(cseq.size()), 32'd9);
        for (int i = 0; i < cseq.size() && i < 9; i++)
            chk($sformatf("t3_cnt_seq%0d", i), 32'(cseq[i]),
                32'(8 - i));
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            chk($sformatf("t3_byte%0d", i), 32'(rx_q[i]),
                32'(t3[i]));
        for (int i = 1; i < st_q.size() && i < 9; i++)
            chk($sformatf("t3_gap%0d", i),
                32'(st_q[i] - st_q[i-1]), 32'd20);

        // Overflow at DIV=100: ten stores, the last one dropped
        wr(A_DIV, 32'd100, 4'h3);
        mon_div = 100;
        rx_q.delete(); st_q.delete();
        for (int i = 0; i < 10; i++)
            wr(A_DATA, 32'(8'h40 + i), 4'h1);
        rd(A_STAT, r);
        chk("t4_status_ovf", r, 32'h8B);
        wr(A_STAT, 32'h8, 4'h1);
        rd(A_STAT, r);
        chk("t4_status_clr", r, 32'h83);
        wait_frames(9, 9400, "t4_frames");
        repeat (1100) @(negedge clk);
        chk("t4_no_drop", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            chk($sformatf("t4_byte%0d", i), 32'(rx_q[i]),
                32'(8'h40 + i));

        // Divisor change mid-frame applies to the next frame
        wr(A_DIV, 32'd4, 4'h3);
        mon_div = 4;
        rx_q.delete(); st_q.delete();
        wr(A_DATA, 32'h3C, 4'h1);
        wr(A_DATA, 32'hC3, 4'h1);
        wait_busy(20, "t5_start");
        mon_div = 8;
        wr(A_DIV, 32'd8, 4'h3);
        rd(A_DIV, r);
        chk("t5_div8", r, 32'd8);
        wait_frames(2, 200, "t5_frames");
        if (rx_q.size() == 2) begin
            chk("t5_byte0", 32'(rx_q[0]), 32'h3C);
            chk("t5_byte1", 32'(rx_q[1]), 32'hC3);
            chk("t5_gap", 32'(st_q[1] - st_q[0]), 32'd40);
        end
        wr(A_DIV, 32'd0, 4'h3);
        rd(A_DIV, r);
        chk("t5_div0", r, 32'd1);

        // Reset in the middle of the data bits
        wr(A_DIV, 32'd4, 4'h3);
        mon_div = 4;
        repeat (2) @(negedge clk);
        rx_q.delete(); st_q.delete();
        wr(A_DATA, 32'h00, 4'h1);
        wr(A_DATA, 32'h00, 4'h1);
        wait_busy(20, "t6_start");
        repeat (8) @(negedge clk);
        chk("t6_tx_low", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_tx_rst", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(A_STAT, r);
        chk("t6_status", r, 32'h4);
        rd(A_DIV, r);
        chk("t6_div", r, 32'd434);
        repeat (300) @(negedge clk);
        chk("t6_no_frame", 32'(rx_q.size()), 32'd0);
        chk("t6_tx_idle", 32'(tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
